// File: rtl/result_buffer.sv
// result_buffer: sums operand pairs and packs two consecutive sums into one
// memory word {upper_sum, lower_sum}. The word is offered to the write-back
// stage over a valid/ready handshake. Halves must arrive lower-then-upper;
// an out-of-order half request raises a one-cycle seq_err_o pulse.
// Optional build macro RESULT_BUFFER_SAT_EN: a half whose sum carries out
// saturates to all-ones instead of wrapping.
module result_buffer #(
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     op_valid_i,
  output logic                     op_ready_o,
  input  logic [DATA_W-1:0]        op_a_i,
  input  logic [DATA_W-1:0]        op_b_i,
  input  logic                     buffer_control_i,
  output logic [MEM_WORD_SIZE-1:0] buff_result_o,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [1:0]               carry_o,
  output logic                     seq_err_o
);

  // The packed word must hold exactly two sums.
  generate
    if (MEM_WORD_SIZE != 2 * DATA_W) begin : g_width_check
      $error("result_buffer: MEM_WORD_SIZE must equal 2*DATA_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOW   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   lower_reg, lower_next;
  logic [DATA_W-1:0]   upper_reg, upper_next;
  logic [1:0]          carry_reg, carry_next;
  logic                seq_err_reg, seq_err_next;
  logic                valid_reg;

  logic                accept;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   half_val;

  assign op_ready_o = (state_reg != FULL) || result_ready_i;
  assign accept     = op_valid_i && op_ready_o;
  assign sum        = {1'b0, op_a_i} + {1'b0, op_b_i};

`ifdef RESULT_BUFFER_SAT_EN
  assign half_val = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`else
  assign half_val = sum[DATA_W-1:0];
`endif

  // Next-state and next-data decode; clear_i overrides everything.
  always_comb begin
    state_next   = state_reg;
    lower_next   = lower_reg;
    upper_next   = upper_reg;
    carry_next   = carry_reg;
    seq_err_next = 1'b0;
    if (clear_i) begin
      state_next = EMPTY;
      lower_next = '0;
      upper_next = '0;
      carry_next = 2'b00;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            if (!buffer_control_i) begin
              lower_next    = half_val;
              carry_next[0] = sum[DATA_W];
              state_next    = LOW;
            end else begin
              seq_err_next = 1'b1;
            end
          end
        end
        LOW: begin
          if (accept) begin
            if (buffer_control_i) begin
              upper_next    = half_val;
              carry_next[1] = sum[DATA_W];
              state_next    = FULL;
            end else begin
              // Repeated lower: keep the newest one but flag the sequence.
              lower_next    = half_val;
              carry_next[0] = sum[DATA_W];
              seq_err_next  = 1'b1;
            end
          end
        end
        FULL: begin
          if (result_ready_i) begin
            state_next = EMPTY;
            if (accept) begin
              if (!buffer_control_i) begin
                lower_next    = half_val;
                carry_next[0] = sum[DATA_W];
                state_next    = LOW;
              end else begin
                seq_err_next = 1'b1;
              end
            end
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= EMPTY;
      lower_reg   <= '0;
      upper_reg   <= '0;
      carry_reg   <= 2'b00;
      seq_err_reg <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      lower_reg   <= lower_next;
      upper_reg   <= upper_next;
      carry_reg   <= carry_next;
      seq_err_reg <= seq_err_next;
      valid_reg   <= (state_next == FULL);
    end
  end

  assign buff_result_o  = {upper_reg, lower_reg};
  assign carry_o        = carry_reg;
  assign seq_err_o      = seq_err_reg;
  assign result_valid_o = valid_reg;

endmodule

// File: tb/tb_result_buffer.sv
// Bench for result_buffer: directed stimulus with hand-computed packed words
// queued to a scoreboard; a monitor pops and compares on every word transfer.
module tb_result_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic        op_valid_i;
  logic        op_ready_o;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        buffer_control_i;
  logic [63:0] buff_result_o;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [1:0]  carry_o;
  logic        seq_err_o;

  typedef struct {
    logic [63:0] word;
    logic [1:0]  carry;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  result_buffer #(.DATA_W(32), .MEM_WORD_SIZE(64)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .clear_i          (clear_i),
    .op_valid_i       (op_valid_i),
    .op_ready_o       (op_ready_o),
    .op_a_i           (op_a_i),
    .op_b_i           (op_b_i),
    .buffer_control_i (buffer_control_i),
    .buff_result_o    (buff_result_o),
    .result_valid_o   (result_valid_o),
    .result_ready_i   (result_ready_i),
    .carry_o          (carry_o),
    .seq_err_o        (seq_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic upper, input logic [31:0] a, input logic [31:0] b);
    op_valid_i       = 1'b1;
    buffer_control_i = upper;
    op_a_i           = a;
    op_b_i           = b;
    tick();
    op_valid_i       = 1'b0;
  endtask

  task automatic expect_word(input logic [63:0] w, input logic [1:0] c);
    exp_t e;
    e.word  = w;
    e.carry = c;
    sb.push_back(e);
  endtask

  // Monitor: every word transfer (valid && ready) is checked against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && result_valid_o && result_ready_i) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %h, want none", buff_result_o);
        end else begin
          e = sb.pop_front();
          chk("xfer_word", buff_result_o, e.word);
          chk("xfer_carry", {62'd0, carry_o}, {62'd0, e.carry});
          $display("xfer word=%h carry=%b", buff_result_o, carry_o);
        end
      end
    end
  end

  initial begin
    logic [31:0] sat_lo;
`ifdef RESULT_BUFFER_SAT_EN
    sat_lo = 32'hFFFFFFFF;
`else
    sat_lo = 32'h00000001;
`endif
    rst_ni = 1'b0; clear_i = 1'b0; op_valid_i = 1'b0; op_a_i = '0; op_b_i = '0;
    buffer_control_i = 1'b0; result_ready_i = 1'b1;

    #2;
    chk("rst_word", buff_result_o, 64'd0);
    chk("rst_valid", {63'd0, result_valid_o}, 64'd0);
    chk("rst_carry", {62'd0, carry_o}, 64'd0);
    chk("rst_seq_err", {63'd0, seq_err_o}, 64'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    tick();
    chk("rst_op_ready", {63'd0, op_ready_o}, 64'd1);

    // Basic pack.
    expect_word(64'h00000030_00000008, 2'b00);
    send(1'b0, 32'h5, 32'h3);
    chk("t1_lower", buff_result_o[31:0], 64'h8);
    chk("t1_valid_low", {63'd0, result_valid_o}, 64'd0);
    send(1'b1, 32'h10, 32'h20);
    chk("t1_valid_full", {63'd0, result_valid_o}, 64'd1);
    chk("t1_word", buff_result_o, 64'h00000030_00000008);
    tick();
    chk("t1_valid_drop", {63'd0, result_valid_o}, 64'd0);

    // Carry on the lower half.
    expect_word({32'h00000002, sat_lo}, 2'b01);
    send(1'b0, 32'hFFFFFFFF, 32'h2);
    send(1'b1, 32'h1, 32'h1);
    chk("t2_carry", {62'd0, carry_o}, 64'd1);
    chk("t2_lower", buff_result_o[31:0], {32'd0, sat_lo});
    tick();

    // Stall while FULL, then drain and accept a lower in the same cycle.
    result_ready_i = 1'b0;
    expect_word(64'h00000004_00000003, 2'b00);
    send(1'b0, 32'h1, 32'h2);
    send(1'b1, 32'h2, 32'h2);
    op_valid_i = 1'b1; buffer_control_i = 1'b0; op_a_i = 32'h9; op_b_i = 32'h1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_ready", {63'd0, op_ready_o}, 64'd0);
      chk("t3_stall_word", buff_result_o, 64'h00000004_00000003);
      tick();
    end
    result_ready_i = 1'b1;
    #1;
    chk("t3_ready_passthru", {63'd0, op_ready_o}, 64'd1);
    tick();
    op_valid_i = 1'b0;
    chk("t3_refill_valid", {63'd0, result_valid_o}, 64'd0);
    chk("t3_refill_word", buff_result_o, 64'h00000004_0000000A);
    expect_word(64'h00000000_0000000A, 2'b00);
    send(1'b1, 32'h0, 32'h0);
    tick();

    // Upper from EMPTY.
    send(1'b1, 32'h7, 32'h7);
    chk("t4_seq_err", {63'd0, seq_err_o}, 64'd1);
    chk("t4_valid", {63'd0, result_valid_o}, 64'd0);
    chk("t4_word", buff_result_o, 64'h00000000_0000000A);
    tick();
    chk("t4_seq_err_pulse", {63'd0, seq_err_o}, 64'd0);

    // Clear with a concurrent upper request.
    send(1'b0, 32'h11, 32'h22);
    chk("t5_lower", buff_result_o[31:0], 64'h33);
    clear_i = 1'b1;
    send(1'b1, 32'h1, 32'h1);
    clear_i = 1'b0;
    chk("t5_clr_word", buff_result_o, 64'd0);
    chk("t5_clr_seq_err", {63'd0, seq_err_o}, 64'd0);
    chk("t5_clr_valid", {63'd0, result_valid_o}, 64'd0);
    expect_word(64'h00000042_00000300, 2'b00);
    send(1'b0, 32'h100, 32'h200);
    send(1'b1, 32'h40, 32'h2);
    tick();

    // Asynchronous reset while in LOW.
    send(1'b0, 32'h5, 32'h5);
    chk("t6_lower", buff_result_o[31:0], 64'hA);
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_async_word", buff_result_o, 64'd0);
    chk("t6_async_valid", {63'd0, result_valid_o}, 64'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    tick();
    chk("t6_op_ready", {63'd0, op_ready_o}, 64'd1);
    send(1'b1, 32'h7, 32'h7);
    chk("t6_seq_err", {63'd0, seq_err_o}, 64'd1);
    chk("t6_valid", {63'd0, result_valid_o}, 64'd0);

    tick(); tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
